otter_id_ex_stage: RTL and testbench
====================================

// Module: otter_id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the OTTER register file. Captures RS1/RS2 read data plus decoded fields.
//  - Bypasses same-cycle WB writes.
//  - Forwards EX/MEM and MEM/WB results into the EX operands.
//  - Detects load-use hazards and inserts one bubble.
//  - Valid/ready handshake on both sides; flush from branch resolution.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register address width (32 architectural regs, x0 hardwired 0)
// PORTS
//  CLK          in   1       clock, all state on posedge
//  RST_N        in   1       asynchronous active-low reset
//  ID_VALID     in   1       decoded instr present
//  ID_READY     out  1       stage accepts ID instr this cycle
//  ID_PC        in   XLEN    instr PC
//  ID_IMM       in   XLEN    decoded immediate
//  ID_RS1_ADDR  in   REG_AW  also drives regfile ADDR1
//  ID_RS2_ADDR  in   REG_AW  also drives regfile ADDR2
//  ID_RD_ADDR   in   REG_AW  destination
//  ID_RD_WE     in   1       instr writes rd
//  ID_IS_LOAD   in   1       instr is a load
//  RF_RS1       in   XLEN    regfile async read data 1
//  RF_RS2       in   XLEN    regfile async read data 2
//  EXMEM_RD / EXMEM_WE / EXMEM_DATA   in  REG_AW/1/XLEN  ALU result one stage ahead
//  MEMWB_RD / MEMWB_WE / MEMWB_DATA   in  REG_AW/1/XLEN  writeback (same bus feeding regfile WR_*)
//  FLUSH        in   1       kill ID input and ID/EX contents
//  EX_VALID     out  1       ID/EX register holds valid instr
//  EX_READY     in   1       EX consumes this cycle
//  EX_PC / EX_IMM / EX_RD_ADDR / EX_RD_WE / EX_IS_LOAD  out  registered copies of ID fields
//  EX_RS1 / EX_RS2  out  XLEN  forwarded operands (combinational from register + fwd mux)
// BEHAVIOUR
//  - Reset: EX_VALID=0; all registered fields = 0; ID_READY reflects comb logic (1 after reset).
//  - Capture: ID_VALID && ID_READY -> register loads on next edge. Latency 1 cycle ID->EX.
//  - WB bypass at capture: MEMWB_WE && MEMWB_RD!=0 && MEMWB_RD==rsN -> capture MEMWB_DATA, not RF_RSn.
//  - x0: operand with addr 0 is always 0; never forwarded, never matched for hazards.
//  - EX forwarding, priority EXMEM > MEMWB > registered value. A source matches when WE=1, RD!=0, RD==rsN.
//  - Load-use hazard: EX_VALID && EX_IS_LOAD && EX_RD_WE && EX_RD_ADDR!=0 && EX_RD_ADDR matches ID rs1/rs2.
//      * Only the rs actually used counts; ID supplies 0 addr for unused rs.
//      * Hazard -> ID_READY=0.
//      * If EX_READY, the register loads a bubble (EX_VALID=0) next edge.
//      * Exactly 1 stall cycle, then normal capture.
//  - Downstream stall: EX_VALID && !EX_READY -> hold all fields; ID_READY=0.
//      * Each held cycle, rs1/rs2 registers re-latch the forwarded EX_RS1/EX_RS2, so producers retiring meanwhile are not lost.
//  - ID_READY = !FLUSH_block_free && (!EX_VALID || EX_READY) && !hazard, except FLUSH forces ID_READY=1 to drain the ID instr.
//  - FLUSH: next edge EX_VALID=0, ID instr discarded.
//      * FLUSH beats hazard, stall and capture in the same cycle.
//  - Reset mid-operation: async clear of EX_VALID, no partial state survives.
//  - No arithmetic beyond compares; all widths exact, no truncation.
// CONFIGURATION
//  OTTER_HAZ_CNT_EN defined: adds outputs STALL_CNT, FWD_CNT (32b each, wrap at 2^32, reset 0).
//    * STALL_CNT increments per load-use stall cycle.
//    * FWD_CNT increments per EX cycle where EX_VALID && EX_READY and >=1 operand forwarded.
//  OTTER_HAZ_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  otter_pipe_pkg (shared):
//    * fwd_sel_e {FWD_NONE, FWD_EXMEM, FWD_MEMWB}
//    * id_ex_t struct (pc, imm, rs1, rs2, rs addrs, rd, rd_we, is_load)
//    * XLEN/REG_AW constants
//  Sub-module otter_fwd_mux: one operand's match/priority select returning fwd_sel_e + data; instantiated twice.
//  This module owns the register, hazard logic and handshake.
// TESTING
//  1. Reset low mid-stream -> EX_VALID=0 immediately; after release ID_READY=1, first capture appears 1 cycle later.
//  2. EXMEM_RD=5,WE=1,DATA=0xAAAA_0001; MEMWB_RD=5,DATA=0x0000_0002; EX instr rs1=5 -> EX_RS1=0xAAAA_0001.
//  3. MEMWB writes x7=0x1234 same cycle ID reads rs2=7 (RF_RS2 stale 0) -> captured EX_RS2=0x1234.
//  4. EX holds load rd=3; ID instr rs1=3 -> ID_READY=0 one cycle, one bubble (EX_VALID=0), then capture.
//     Load rd=0 -> no stall.
//  5. EX_READY=0 for 3 cycles while EXMEM/MEMWB retire rd=4=0x55 -> EX_RS1 (rs1=4) still 0x55 after release.
//  6. FLUSH with hazard and EX_READY=0 -> next cycle EX_VALID=0, ID_READY was 1, ID instr dropped.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: shared widths, forwarding select enum, ID/EX payload struct and register-match helper.
package otter_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic              is_load;
    } id_ex_t;

    function automatic logic reg_hit(
        input logic              we,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/otter_fwd_mux.sv
// otter_fwd_mux: picks the forwarding source for one EX operand, EX/MEM winning over MEM/WB.
module otter_fwd_mux
    import otter_pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_we,
    input  logic [XLEN-1:0]   exmem_data,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_we,
    input  logic [XLEN-1:0]   memwb_data,
    output fwd_sel_e          sel,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        sel  = reg_hit(exmem_we, exmem_rd, rs_addr) ? FWD_EXMEM :
               reg_hit(memwb_we, memwb_rd, rs_addr) ? FWD_MEMWB : FWD_NONE;
        data = (sel == FWD_MEMWB) ? memwb_data : exmem_data;
    end

endmodule

// File: rtl/otter_id_ex_stage.sv
// otter_id_ex_stage: ID/EX register with WB bypass, EX forwarding, load-use stall and flush.
// Define OTTER_HAZ_CNT_EN to add the stall_cnt/fwd_cnt event counters.
module otter_id_ex_stage
    import otter_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [XLEN-1:0]   rf_rs1,
    input  logic [XLEN-1:0]   rf_rs2,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_we,
    input  logic [XLEN-1:0]   exmem_data,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_we,
    input  logic [XLEN-1:0]   memwb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_rs1,
    output logic [XLEN-1:0]   ex_rs2
`ifdef OTTER_HAZ_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    id_ex_t            ex_q, ex_d;
    logic              ex_valid_q, ex_valid_d;
    fwd_sel_e          sel1, sel2;
    logic [XLEN-1:0]   fwd1, fwd2;
    logic [XLEN-1:0]   cap_rs1, cap_rs2;
    logic              hazard, stall_dn, capture;

    otter_fwd_mux u_fwd_rs1 (
        .rs_addr    (ex_q.rs1_addr),
        .exmem_rd   (exmem_rd),
        .exmem_we   (exmem_we),
        .exmem_data (exmem_data),
        .memwb_rd   (memwb_rd),
        .memwb_we   (memwb_we),
        .memwb_data (memwb_data),
        .sel        (sel1),
        .data       (fwd1)
    );

    otter_fwd_mux u_fwd_rs2 (
        .rs_addr    (ex_q.rs2_addr),
        .exmem_rd   (exmem_rd),
        .exmem_we   (exmem_we),
        .exmem_data (exmem_data),
        .memwb_rd   (memwb_rd),
        .memwb_we   (memwb_we),
        .memwb_data (memwb_data),
        .sel        (sel2),
        .data       (fwd2)
    );

    // x0 is captured as 0 and never matches a forwarding source, so it stays 0
    assign ex_rs1     = (sel1 == FWD_NONE) ? ex_q.rs1 : fwd1;
    assign ex_rs2     = (sel2 == FWD_NONE) ? ex_q.rs2 : fwd2;
    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_q.pc;
    assign ex_imm     = ex_q.imm;
    assign ex_rd_addr = ex_q.rd;
    assign ex_rd_we   = ex_q.rd_we;
    assign ex_is_load = ex_q.is_load;

    always_comb begin
        hazard   = ex_valid_q && ex_q.is_load && ex_q.rd_we && (ex_q.rd != '0) &&
                   ((ex_q.rd == id_rs1_addr) || (ex_q.rd == id_rs2_addr));
        stall_dn = ex_valid_q && !ex_ready;
        id_ready = flush || (!stall_dn && !hazard);
        capture  = !flush && !stall_dn && !hazard && id_valid;
        cap_rs1  = (id_rs1_addr == '0) ? '0 :
                   reg_hit(memwb_we, memwb_rd, id_rs1_addr) ? memwb_data : rf_rs1;
        cap_rs2  = (id_rs2_addr == '0) ? '0 :
                   reg_hit(memwb_we, memwb_rd, id_rs2_addr) ? memwb_data : rf_rs2;
        ex_d       = ex_q;
        ex_valid_d = capture || (stall_dn && !flush);
        if (!flush && stall_dn) begin
            // re-latch forwarded operands so producers retiring during the stall are kept
            ex_d.rs1 = ex_rs1;
            ex_d.rs2 = ex_rs2;
        end else if (capture) begin
            ex_d.pc       = id_pc;
            ex_d.imm      = id_imm;
            ex_d.rs1      = cap_rs1;
            ex_d.rs2      = cap_rs2;
            ex_d.rs1_addr = id_rs1_addr;
            ex_d.rs2_addr = id_rs2_addr;
            ex_d.rd       = id_rd_addr;
            ex_d.rd_we    = id_rd_we;
            ex_d.is_load  = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

`ifdef OTTER_HAZ_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, id_valid && hazard && !flush};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, ex_valid_q && ex_ready &&
                                          ((sel1 != FWD_NONE) || (sel2 != FWD_NONE))};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_otter_id_ex_stage.sv
// tb_otter_id_ex_stage: scoreboard bench for the ID/EX stage (default build).
module tb_otter_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rd_we, id_is_load;
    logic [31:0] rf_rs1, rf_rs2;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_data, memwb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we, ex_is_load;
    logic [31:0] ex_rs1, ex_rs2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otter_id_ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_imm      (id_imm),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rd_addr  (id_rd_addr),
        .id_rd_we    (id_rd_we),
        .id_is_load  (id_is_load),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .exmem_rd    (exmem_rd),
        .exmem_we    (exmem_we),
        .exmem_data  (exmem_data),
        .memwb_rd    (memwb_rd),
        .memwb_we    (memwb_we),
        .memwb_data  (memwb_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rd_we    (ex_rd_we),
        .ex_is_load  (ex_is_load),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // sample at negedge (pop scoreboard on EX consume), then advance to just after posedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (ex_valid && ex_ready) begin
            if (sb.size() == 0) chk("sb_unexpected", 32'(ex_valid), 32'd0);
            else begin
                e = sb.pop_front();
                chk("pc", ex_pc, e.pc);
                chk("imm", ex_imm, e.pc ^ 32'h0000_FFFF);
                chk("rs1", ex_rs1, e.rs1);
                chk("rs2", ex_rs2, e.rs2);
                chk("rd", 32'(ex_rd_addr), 32'(e.rd));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
                         input logic ld);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_imm      = pc ^ 32'h0000_FFFF;
        id_rs1_addr = a1;
        id_rs2_addr = a2;
        rf_rs1      = r1;
        rf_rs2      = r2;
        id_rd_addr  = rd;
        id_rd_we    = 1'b1;
        id_is_load  = ld;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [4:0] rd);
        sb.push_back('{pc: pc, rs1: e1, rs2: e2, rd: rd});
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs1_addr = '0;
        id_rs2_addr = '0;
        id_is_load  = 1'b0;
    endtask

    task automatic clr_fwd();
        exmem_we = 1'b0;
        exmem_rd = '0;
        memwb_we = 1'b0;
        memwb_rd = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        exmem_data = '0;
        memwb_data = '0;
        id_pc = '0;
        id_imm = '0;
        id_rd_addr = '0;
        id_rd_we = 1'b0;
        rf_rs1 = '0;
        rf_rs2 = '0;
        idle();
        clr_fwd();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_ready", 32'(id_ready), 32'd1);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rd", 32'(ex_rd_addr), 32'd0);
        rst_n = 1'b1;

        // reset mid-stream clears a captured instruction without waiting for a clock
        drive(32'h100, 5'd1, 5'd2, 32'h11, 32'h22, 5'd9, 1'b0);
        tick();
        idle();
        chk("cap_valid", 32'(ex_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_clr", 32'(ex_valid), 32'd0);
        chk("async_pc", ex_pc, 32'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(id_ready), 32'd1);
        drive(32'h104, 5'd1, 5'd2, 32'h33, 32'h44, 5'd10, 1'b0);
        push(32'h104, 32'h33, 32'h44, 5'd10);
        tick();
        idle();
        chk("lat1_valid", 32'(ex_valid), 32'd1);
        tick();

        // EX/MEM beats MEM/WB on the same register
        drive(32'h200, 5'd5, 5'd6, 32'h50, 32'h60, 5'd12, 1'b0);
        push(32'h200, 32'hAAAA_0001, 32'h60, 5'd12);
        tick();
        idle();
        exmem_rd = 5'd5; exmem_we = 1'b1; exmem_data = 32'hAAAA_0001;
        memwb_rd = 5'd5; memwb_we = 1'b1; memwb_data = 32'h0000_0002;
        tick();
        clr_fwd();

        // x0 ignores regfile data and a x0-targeting EX/MEM write; rs2 from MEM/WB
        drive(32'h204, 5'd0, 5'd6, 32'hDEAD, 32'h60, 5'd13, 1'b0);
        push(32'h204, 32'h0, 32'h66, 5'd13);
        tick();
        idle();
        exmem_rd = 5'd0; exmem_we = 1'b1; exmem_data = 32'hBAD;
        memwb_rd = 5'd6; memwb_we = 1'b1; memwb_data = 32'h66;
        tick();
        clr_fwd();

        // WB write in the capture cycle bypasses the stale regfile read
        drive(32'h300, 5'd0, 5'd7, 32'h0, 32'h0, 5'd14, 1'b0);
        memwb_rd = 5'd7; memwb_we = 1'b1; memwb_data = 32'h1234;
        push(32'h300, 32'h0, 32'h1234, 5'd14);
        tick();
        clr_fwd();
        idle();
        tick();

        // load-use: one bubble then capture
        drive(32'h400, 5'd1, 5'd2, 32'h1, 32'h2, 5'd3, 1'b1);
        push(32'h400, 32'h1, 32'h2, 5'd3);
        tick();
        drive(32'h404, 5'd3, 5'd0, 32'h333, 32'h0, 5'd15, 1'b0);
        push(32'h404, 32'h10AD, 32'h0, 5'd15);
        #2;
        chk("haz_ready", 32'(id_ready), 32'd0);
        tick();
        chk("bubble", 32'(ex_valid), 32'd0);
        chk("post_ready", 32'(id_ready), 32'd1);
        tick();
        idle();
        memwb_rd = 5'd3; memwb_we = 1'b1; memwb_data = 32'h10AD;
        chk("haz_cap", 32'(ex_valid), 32'd1);
        tick();
        clr_fwd();

        // load targeting x0 never stalls
        drive(32'h410, 5'd1, 5'd2, 32'h5, 32'h6, 5'd0, 1'b1);
        push(32'h410, 32'h5, 32'h6, 5'd0);
        tick();
        drive(32'h414, 5'd0, 5'd0, 32'h7, 32'h8, 5'd16, 1'b0);
        push(32'h414, 32'h0, 32'h0, 5'd16);
        #2;
        chk("ld_x0_ready", 32'(id_ready), 32'd1);
        tick();
        idle();
        chk("ld_x0_cap", 32'(ex_valid), 32'd1);
        tick();

        // downstream stall: producer retires through EX/MEM then MEM/WB while held
        drive(32'h500, 5'd4, 5'd0, 32'h0, 32'h0, 5'd17, 1'b0);
        push(32'h500, 32'h55, 32'h0, 5'd17);
        tick();
        idle();
        ex_ready = 1'b0;
        exmem_rd = 5'd4; exmem_we = 1'b1; exmem_data = 32'h55;
        #2;
        chk("hold_fwd", ex_rs1, 32'h55);
        chk("hold_ready", 32'(id_ready), 32'd0);
        tick();
        exmem_we = 1'b0;
        memwb_rd = 5'd4; memwb_we = 1'b1; memwb_data = 32'h55;
        tick();
        clr_fwd();
        #2;
        chk("hold_keep", ex_rs1, 32'h55);
        tick();
        ex_ready = 1'b1;
        #2;
        chk("hold_valid", 32'(ex_valid), 32'd1);
        tick();

        // flush beats hazard and downstream stall
        drive(32'h600, 5'd1, 5'd2, 32'h0, 32'h0, 5'd3, 1'b1);
        tick();
        drive(32'h604, 5'd3, 5'd0, 32'h0, 32'h0, 5'd18, 1'b0);
        ex_ready = 1'b0;
        flush = 1'b1;
        #2;
        chk("flush_ready", 32'(id_ready), 32'd1);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        flush = 1'b0;
        idle();
        ex_ready = 1'b1;
        tick();
        chk("flush_drop", 32'(ex_valid), 32'd0);

        // back-to-back stream, one instruction per cycle
        for (int i = 0; i < 8; i++) begin
            logic [31:0] r1, r2;
            logic [4:0]  a1, a2, rd;
            r1 = $urandom;
            r2 = $urandom;
            a1 = 5'($urandom_range(31, 1));
            a2 = 5'($urandom_range(31, 1));
            rd = 5'($urandom_range(31, 1));
            drive(32'h700 + 32'(i * 4), a1, a2, r1, r2, rd, 1'b0);
            push(32'h700 + 32'(i * 4), r1, r2, rd);
            tick();
        end
        idle();
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
